// File: rtl/rect_finder.sv
// Scans a latched binary matrix for axis-aligned rectangles whose four corners are 1,
// reporting each hit through a valid/ready handshake in lexicographic (r1,r2,c1,c2) order.
module rect_finder #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    localparam int RW    = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1,
    localparam int CW    = ($clog2(COLS) > 0) ? $clog2(COLS) : 1,
    localparam int NCAND = (ROWS * (ROWS - 1) / 2) * (COLS * (COLS - 1) / 2),
    localparam int NW    = $clog2(NCAND + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] m_in,
    output logic                 busy,
    output logic                 found_valid,
    input  logic                 found_ready,
    output logic [RW-1:0]        r1,
    output logic [RW-1:0]        r2,
    output logic [CW-1:0]        c1,
    output logic [CW-1:0]        c2,
    output logic                 done,
    output logic [NW-1:0]        hit_count
);

    localparam int IW = ($clog2(ROWS * COLS) > 0) ? $clog2(ROWS * COLS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [RW-1:0] RLAST = RW'(ROWS - 1);
    localparam logic [RW-1:0] RPEN  = RW'(ROWS - 2);
    localparam logic [CW-1:0] CLAST = CW'(COLS - 1);
    localparam logic [CW-1:0] CPEN  = CW'(COLS - 2);

    logic [1:0]           state;
    logic [ROWS*COLS-1:0] mat;
    logic [RW-1:0]        cr1, cr2, nr1, nr2;
    logic [CW-1:0]        cc1, cc2, nc1, nc2;
    logic                 hit, last;

    function automatic logic bit_at(input logic [ROWS*COLS-1:0] mm,
                                    input logic [RW-1:0] r, input logic [CW-1:0] c);
        logic [IW-1:0] idx;
        idx = IW'(c) * IW'(ROWS) + IW'(r);
        return mm[idx];
    endfunction

    assign hit  = bit_at(mat, cr1, cc1) & bit_at(mat, cr1, cc2)
                & bit_at(mat, cr2, cc1) & bit_at(mat, cr2, cc2);
    assign last = (cr1 == RPEN) && (cr2 == RLAST) && (cc1 == CPEN) && (cc2 == CLAST);

    // Successor candidate: c2 fastest, then c1, r2, r1; lower bounds reset to the tightest legal pair.
    always_comb begin
        nr1 = cr1;
        nr2 = cr2;
        nc1 = cc1;
        nc2 = cc2;
        if (cc2 != CLAST) begin
            nc2 = cc2 + CW'(1);
        end else if (cc1 != CPEN) begin
            nc1 = cc1 + CW'(1);
            nc2 = cc1 + CW'(2);
        end else if (cr2 != RLAST) begin
            nr2 = cr2 + RW'(1);
            nc1 = '0;
            nc2 = CW'(1);
        end else begin
            nr1 = cr1 + RW'(1);
            nr2 = cr1 + RW'(2);
            nc1 = '0;
            nc2 = CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mat       <= '0;
            cr1       <= '0;
            cr2       <= '0;
            cc1       <= '0;
            cc2       <= '0;
            r1        <= '0;
            r2        <= '0;
            c1        <= '0;
            c2        <= '0;
            hit_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mat       <= m_in;
                        hit_count <= '0;
                        cr1       <= '0;
                        cr2       <= RW'(1);
                        cc1       <= '0;
                        cc2       <= CW'(1);
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        r1        <= cr1;
                        r2        <= cr2;
                        c1        <= cc1;
                        c2        <= cc2;
                        hit_count <= hit_count + NW'(1);
                        state     <= S_HOLD;
                    end else if (last) begin
                        state <= S_DONE;
                    end else begin
                        {cr1, cr2, cc1, cc2} <= {nr1, nr2, nc1, nc2};
                    end
                end
                S_HOLD: begin
                    if (found_ready) begin
                        if (last) begin
                            state <= S_DONE;
                        end else begin
                            {cr1, cr2, cc1, cc2} <= {nr1, nr2, nc1, nc2};
                            state <= S_SCAN;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign found_valid = (state == S_HOLD);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_rect_finder.sv
// Directed bench for rect_finder (4x4): empty, single hit, full matrix, backpressure,
// reset during HOLD and start re-pulsed mid-scan.
module tb_rect_finder;

    logic        clk = 1'b0;
    logic        rst_n, start, found_ready;
    logic [15:0] m_in;
    logic        busy, found_valid, done;
    logic [1:0]  r1, r2, c1, c2;
    logic [5:0]  hit_count;

    int checks   = 0;
    int failures = 0;

    int hr1[$], hr2[$], hc1[$], hc2[$];
    int unstable;
    int done_cyc;
    int done_pulses;

    rect_finder #(.ROWS(4), .COLS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m_in(m_in),
        .busy(busy), .found_valid(found_valid), .found_ready(found_ready),
        .r1(r1), .r2(r2), .c1(c1), .c2(c2), .done(done), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    // Issues a start, then observes at each falling edge; cyc counts rising edges after the start edge.
    task automatic run_search(input logic [15:0] mat, input int rdelay, input int pulse_at);
        int hv;
        hv = 0;
        hr1.delete(); hr2.delete(); hc1.delete(); hc2.delete();
        unstable    = 0;
        done_cyc    = -1;
        done_pulses = 0;
        found_ready = (rdelay == 0);
        @(negedge clk);
        m_in  = mat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = (cyc == pulse_at);
            if (cyc == pulse_at) m_in = 16'hFFFF;
            if (found_valid) begin
                hv++;
                if (hv == 1) begin
                    hr1.push_back(int'(r1)); hr2.push_back(int'(r2));
                    hc1.push_back(int'(c1)); hc2.push_back(int'(c2));
                end else if (int'(r1) != hr1[$] || int'(r2) != hr2[$] ||
                             int'(c1) != hc1[$] || int'(c2) != hc2[$]) begin
                    unstable++;
                end
                if (rdelay > 0) found_ready = (hv > rdelay);
            end else begin
                hv = 0;
                if (rdelay > 0) found_ready = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; m_in = 16'hFFFF; found_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, found_valid, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl busy/valid/done got %b expected 000", {busy, found_valid, done});
        end
        checks++;
        if ({r1, r2, c1, c2, hit_count} !== 14'd0) begin
            failures++;
            $display("FAIL reset_data got r1=%0d r2=%0d c1=%0d c2=%0d hc=%0d expected all 0",
                     r1, r2, c1, c2, hit_count);
        end
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored busy got %b expected 0", busy);
        end
    endtask

    task automatic test_empty;
        run_search(16'h0000, 0, -1);
        checks++;
        if (done_cyc !== 36) begin
            failures++;
            $display("FAIL empty_done_cycle got %0d expected 36", done_cyc);
        end
        checks++;
        if (hr1.size() !== 0) begin
            failures++;
            $display("FAIL empty_hits got %0d expected 0", hr1.size());
        end
        checks++;
        if (hit_count !== 6'd0) begin
            failures++;
            $display("FAIL empty_hit_count got %0d expected 0", hit_count);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL empty_after_done busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_single;
        run_search(16'h5050, 0, -1);
        checks++;
        if (done_cyc !== 37) begin
            failures++;
            $display("FAIL single_done_cycle got %0d expected 37", done_cyc);
        end
        checks++;
        if (hr1.size() !== 1) begin
            failures++;
            $display("FAIL single_hits got %0d expected 1", hr1.size());
        end else if (hr1[0] !== 0 || hr2[0] !== 2 || hc1[0] !== 1 || hc2[0] !== 3) begin
            checks++;
            failures++;
            $display("FAIL single_coords got (%0d,%0d,%0d,%0d) expected (0,2,1,3)",
                     hr1[0], hr2[0], hc1[0], hc2[0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (hit_count !== 6'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_hold hit_count=%0d busy=%b expected 1 and 0", hit_count, busy);
        end
        checks++;
        if ({r1, r2, c1, c2} !== {2'd0, 2'd2, 2'd1, 2'd3}) begin
            failures++;
            $display("FAIL single_coords_held got (%0d,%0d,%0d,%0d) expected (0,2,1,3)", r1, r2, c1, c2);
        end
    endtask

    task automatic test_full;
        int idx;
        int bad;
        run_search(16'hFFFF, 0, -1);
        checks++;
        if (hr1.size() !== 36 || done_cyc !== 72) begin
            failures++;
            $display("FAIL full_hits got %0d hits done at %0d expected 36 hits done at 72",
                     hr1.size(), done_cyc);
        end
        idx = 0;
        bad = 0;
        for (int a = 0; a < 3; a++)
            for (int b = a + 1; b < 4; b++)
                for (int c = 0; c < 3; c++)
                    for (int d = c + 1; d < 4; d++) begin
                        if (idx < hr1.size() && bad == 0) begin
                            checks++;
                            if (hr1[idx] !== a || hr2[idx] !== b || hc1[idx] !== c || hc2[idx] !== d) begin
                                failures++;
                                bad = 1;
                                $display("FAIL full_order hit %0d got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)",
                                         idx, hr1[idx], hr2[idx], hc1[idx], hc2[idx], a, b, c, d);
                            end
                        end
                        idx++;
                    end
        checks++;
        if (hit_count !== 6'd36) begin
            failures++;
            $display("FAIL full_hit_count got %0d expected 36", hit_count);
        end
    endtask

    task automatic test_backpressure;
        run_search(16'h5050, 5, -1);
        checks++;
        if (hr1.size() !== 1 || unstable !== 0) begin
            failures++;
            $display("FAIL bp_hold hits=%0d unstable=%0d expected 1 and 0", hr1.size(), unstable);
        end
        checks++;
        if (done_cyc !== 42) begin
            failures++;
            $display("FAIL bp_done_cycle got %0d expected 42", done_cyc);
        end
        checks++;
        if (hit_count !== 6'd1) begin
            failures++;
            $display("FAIL bp_hit_count got %0d expected 1", hit_count);
        end
    endtask

    task automatic test_reset_in_hold;
        int nvalid;
        int hit_seen;
        nvalid = 0;
        hit_seen = 0;
        found_ready = 1'b1;
        @(negedge clk);
        m_in = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (found_valid) begin
                nvalid++;
                if (nvalid == 3) begin
                    hit_seen = 1;
                    break;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (hit_seen !== 1 || {r1, r2, c1, c2} !== {2'd0, 2'd1, 2'd0, 2'd3} || hit_count !== 6'd3) begin
            failures++;
            $display("FAIL rst_hold_third got seen=%0d (%0d,%0d,%0d,%0d) hc=%0d expected 1 (0,1,0,3) 3",
                     hit_seen, r1, r2, c1, c2, hit_count);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, found_valid, done, r1, r2, c1, c2, hit_count} !== 17'd0) begin
            failures++;
            $display("FAIL rst_hold_clear got busy=%b fv=%b done=%b (%0d,%0d,%0d,%0d) hc=%0d expected all 0",
                     busy, found_valid, done, r1, r2, c1, c2, hit_count);
        end
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) done_pulses++;
            @(negedge clk);
        end
        checks++;
        if (done_pulses !== 0) begin
            failures++;
            $display("FAIL rst_hold_no_done got %0d active cycles expected 0", done_pulses);
        end
        run_search(16'hFFFF, 0, -1);
        checks++;
        if (hr1.size() !== 36 || hr1[0] !== 0 || hr2[0] !== 1 || hc1[0] !== 0 || hc2[0] !== 1) begin
            failures++;
            $display("FAIL rst_hold_restart got %0d hits expected 36 starting (0,1,0,1)", hr1.size());
        end
    endtask

    task automatic test_start_ignored;
        run_search(16'h5050, 0, 3);
        checks++;
        if (hr1.size() !== 1 || done_cyc !== 37) begin
            failures++;
            $display("FAIL restart_ignored got %0d hits done at %0d expected 1 hit done at 37",
                     hr1.size(), done_cyc);
        end else begin
            checks++;
            if (hr1[0] !== 0 || hr2[0] !== 2 || hc1[0] !== 1 || hc2[0] !== 3) begin
                failures++;
                $display("FAIL restart_coords got (%0d,%0d,%0d,%0d) expected (0,2,1,3)",
                         hr1[0], hr2[0], hc1[0], hc2[0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_empty;
        test_single;
        test_full;
        test_backpressure;
        test_reset_in_hold;
        test_start_ignored;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
